// File: rtl/ex_fwd_stage.sv
// ex_fwd_stage
//   EX-stage operand unit for the five-stage MIPS pipeline. Picks the ALU
//   operands and store data from the register file or one of the forward
//   buses, decodes the destination register, runs a multi-cycle mult/div
//   unit that owns HI/LO, and holds the E/M pipeline register.
//
// Ports
//   clk, reset_n            rising-edge clock, asynchronous active-low reset
//   stall_i, flush_i        E/M hold / bubble (flush has priority)
//   alu_src_i               1: SrcB takes the extended immediate
//   reg_dst_i, rt_i, rd_i   destination register decode (rt / rd / 31 / 0)
//   regwrite_i              instruction writes the GPR
//   fwd_rs_i, fwd_rt_i      operand source selects (0 = register file)
//   rd1_i, rd2_i, ext_i     register-file values and extended immediate
//   fwd_bus_i               NSRC-1 forward buses, bus k at [k*DW-1:(k-1)*DW]
//   alu_res_i               ALU result for the current operands
//   md_start_i, md_op_i     start mult/div (00 mult, 01 multu, 10 div, 11 divu)
//   md_wr_i                 bit1 mthi, bit0 mtlo, value is SrcA
//   srca_o, srcb_o, wreg_e_o  combinational operands and destination
//   md_busy_o, hi_o, lo_o   mult/div status and HI/LO registers
//   alures_m_o, wdata_m_o, wreg_m_o, regwrite_m_o  E/M register outputs

module ex_fwd_stage #(
  parameter int DW      = 32,
  parameter int NSRC    = 5,
  parameter int SELW    = 3,
  parameter int MUL_CYC = 5,
  parameter int DIV_CYC = 10
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   stall_i,
  input  logic                   flush_i,
  input  logic                   alu_src_i,
  input  logic [1:0]             reg_dst_i,
  input  logic [4:0]             rt_i,
  input  logic [4:0]             rd_i,
  input  logic                   regwrite_i,
  input  logic [SELW-1:0]        fwd_rs_i,
  input  logic [SELW-1:0]        fwd_rt_i,
  input  logic [DW-1:0]          rd1_i,
  input  logic [DW-1:0]          rd2_i,
  input  logic [DW-1:0]          ext_i,
  input  logic [(NSRC-1)*DW-1:0] fwd_bus_i,
  input  logic [DW-1:0]          alu_res_i,
  input  logic                   md_start_i,
  input  logic [1:0]             md_op_i,
  input  logic [1:0]             md_wr_i,
  output logic [DW-1:0]          srca_o,
  output logic [DW-1:0]          srcb_o,
  output logic [4:0]             wreg_e_o,
  output logic                   md_busy_o,
  output logic [DW-1:0]          hi_o,
  output logic [DW-1:0]          lo_o,
  output logic [DW-1:0]          alures_m_o,
  output logic [DW-1:0]          wdata_m_o,
  output logic [4:0]             wreg_m_o,
  output logic                   regwrite_m_o
);

  localparam int MAXC = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC + 1) : 1;

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

  logic [DW-1:0] fwd_a;
  logic [DW-1:0] fwd_b;

  md_state_t     md_state, md_state_n;
  logic [CW-1:0] md_cnt, md_cnt_n;
  logic [1:0]    md_op_q, md_op_n;
  logic [DW-1:0] md_a, md_a_n;
  logic [DW-1:0] md_b, md_b_n;
  logic [DW-1:0] hi_q, hi_n;
  logic [DW-1:0] lo_q, lo_n;

  logic signed [2*DW-1:0] prod_s;
  logic [2*DW-1:0]        prod_u;
  logic [DW-1:0]          div_b;
  logic signed [DW-1:0]   quot_s;
  logic signed [DW-1:0]   rem_s;
  logic [DW-1:0]          quot_u;
  logic [DW-1:0]          rem_u;

  // Operand forwarding: select 0 is the register file, selects beyond the
  // last bus yield zero so an illegal select can never leak stale data.
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    if (fwd_rs_i == '0) fwd_a = rd1_i;
    if (fwd_rt_i == '0) fwd_b = rd2_i;
    for (int k = 1; k < NSRC; k++) begin
      if (fwd_rs_i == SELW'(k)) fwd_a = fwd_bus_i[(k-1)*DW +: DW];
      if (fwd_rt_i == SELW'(k)) fwd_b = fwd_bus_i[(k-1)*DW +: DW];
    end
  end

  // Store data is the forwarded rt value and never sees the immediate mux.
  assign srca_o = fwd_a;
  assign srcb_o = alu_src_i ? ext_i : fwd_b;

  // Destination register decode; code 3 targets $0, i.e. no visible write.
  always_comb begin
    wreg_e_o = 5'd0;
    case (reg_dst_i)
      2'd0:    wreg_e_o = rt_i;
      2'd1:    wreg_e_o = rd_i;
      2'd2:    wreg_e_o = 5'd31;
      default: wreg_e_o = 5'd0;
    endcase
  end

  // E/M pipeline register: flush beats stall, stall holds, else capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alures_m_o   <= '0;
      wdata_m_o    <= '0;
      wreg_m_o     <= '0;
      regwrite_m_o <= 1'b0;
    end else if (flush_i) begin
      alures_m_o   <= '0;
      wdata_m_o    <= '0;
      wreg_m_o     <= '0;
      regwrite_m_o <= 1'b0;
    end else if (!stall_i) begin
      alures_m_o   <= alu_res_i;
      wdata_m_o    <= fwd_b;
      wreg_m_o     <= wreg_e_o;
      regwrite_m_o <= regwrite_i;
    end
  end

  // Result datapath works on the operands latched at start. A zero divisor
  // is replaced by one so the divider never produces X; the result is then
  // discarded by the state machine anyway.
  always_comb begin
    div_b  = (md_b == '0) ? DW'(1) : md_b;
    prod_s = $signed({{DW{md_a[DW-1]}}, md_a}) * $signed({{DW{md_b[DW-1]}}, md_b});
    prod_u = {{DW{1'b0}}, md_a} * {{DW{1'b0}}, md_b};
    quot_s = $signed(md_a) / $signed(div_b);
    rem_s  = $signed(md_a) % $signed(div_b);
    quot_u = md_a / div_b;
    rem_u  = md_a % div_b;
  end

  // Mult/div next-state logic. In IDLE an unstalled start takes priority over
  // mthi/mtlo; in BUSY everything except the countdown is ignored, so the
  // hazard unit is responsible for stalling dependent instructions.
  always_comb begin
    md_state_n = md_state;
    md_cnt_n   = md_cnt;
    md_op_n    = md_op_q;
    md_a_n     = md_a;
    md_b_n     = md_b;
    hi_n       = hi_q;
    lo_n       = lo_q;
    case (md_state)
      MD_IDLE: begin
        if (!stall_i) begin
          if (md_start_i) begin
            md_state_n = MD_BUSY;
            md_cnt_n   = md_op_i[1] ? CW'(DIV_CYC - 1) : CW'(MUL_CYC - 1);
            md_op_n    = md_op_i;
            md_a_n     = srca_o;
            md_b_n     = srcb_o;
          end else begin
            if (md_wr_i[1]) hi_n = srca_o;
            if (md_wr_i[0]) lo_n = srca_o;
          end
        end
      end
      MD_BUSY: begin
        if (md_cnt == '0) begin
          md_state_n = MD_IDLE;
          case (md_op_q)
            2'b00: begin
              hi_n = prod_s[2*DW-1:DW];
              lo_n = prod_s[DW-1:0];
            end
            2'b01: begin
              hi_n = prod_u[2*DW-1:DW];
              lo_n = prod_u[DW-1:0];
            end
            2'b10: begin
              if (md_b != '0) begin
                hi_n = rem_s;
                lo_n = quot_s;
              end
            end
            default: begin
              if (md_b != '0) begin
                hi_n = rem_u;
                lo_n = quot_u;
              end
            end
          endcase
        end else begin
          md_cnt_n = md_cnt - CW'(1);
        end
      end
      default: md_state_n = MD_IDLE;
    endcase
  end

  // Mult/div state and HI/LO; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      md_state <= MD_IDLE;
      md_cnt   <= '0;
      md_op_q  <= '0;
      md_a     <= '0;
      md_b     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      md_state <= md_state_n;
      md_cnt   <= md_cnt_n;
      md_op_q  <= md_op_n;
      md_a     <= md_a_n;
      md_b     <= md_b_n;
      hi_q     <= hi_n;
      lo_q     <= lo_n;
    end
  end

  assign md_busy_o = (md_state == MD_BUSY);
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;

endmodule

// File: tb/tb_ex_fwd_stage.sv
// tb_ex_fwd_stage
//   Self-checking bench for ex_fwd_stage: directed cases followed by random
//   traffic, all compared against a behavioural model of the EX stage.

module tb_ex_fwd_stage;

  localparam int DW      = 32;
  localparam int NSRC    = 5;
  localparam int SELW    = 3;
  localparam int MUL_CYC = 5;
  localparam int DIV_CYC = 10;

  logic                   clk;
  logic                   reset_n;
  logic                   stall_i, flush_i, alu_src_i, regwrite_i;
  logic [1:0]             reg_dst_i;
  logic [4:0]             rt_i, rd_i;
  logic [SELW-1:0]        fwd_rs_i, fwd_rt_i;
  logic [DW-1:0]          rd1_i, rd2_i, ext_i, alu_res_i;
  logic [(NSRC-1)*DW-1:0] fwd_bus_i;
  logic                   md_start_i;
  logic [1:0]             md_op_i, md_wr_i;
  logic [DW-1:0]          srca_o, srcb_o, hi_o, lo_o, alures_m_o, wdata_m_o;
  logic [4:0]             wreg_e_o, wreg_m_o;
  logic                   md_busy_o, regwrite_m_o;

  int nCompared   = 0;
  int nMismatched = 0;

  // Behavioural model state
  logic [31:0] mAluM, mWdM, mHi, mLo, mA, mB;
  logic [4:0]  mWregM;
  logic        mRegwM;
  bit          mBusy;
  int          mLeft;
  logic [1:0]  mOp;

  ex_fwd_stage #(
    .DW(DW), .NSRC(NSRC), .SELW(SELW), .MUL_CYC(MUL_CYC), .DIV_CYC(DIV_CYC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .stall_i(stall_i), .flush_i(flush_i),
    .alu_src_i(alu_src_i), .reg_dst_i(reg_dst_i), .rt_i(rt_i), .rd_i(rd_i),
    .regwrite_i(regwrite_i), .fwd_rs_i(fwd_rs_i), .fwd_rt_i(fwd_rt_i),
    .rd1_i(rd1_i), .rd2_i(rd2_i), .ext_i(ext_i), .fwd_bus_i(fwd_bus_i),
    .alu_res_i(alu_res_i), .md_start_i(md_start_i), .md_op_i(md_op_i),
    .md_wr_i(md_wr_i), .srca_o(srca_o), .srcb_o(srcb_o), .wreg_e_o(wreg_e_o),
    .md_busy_o(md_busy_o), .hi_o(hi_o), .lo_o(lo_o), .alures_m_o(alures_m_o),
    .wdata_m_o(wdata_m_o), .wreg_m_o(wreg_m_o), .regwrite_m_o(regwrite_m_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so a stuck run still ends with a report.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Source table view of forwarding: entry 0 the register file, then buses.
  function automatic logic [31:0] fwdValue(input logic [SELW-1:0] sel, input logic [31:0] rf);
    logic [31:0] srcs [NSRC];
    srcs[0] = rf;
    for (int k = 1; k < NSRC; k++) srcs[k] = fwd_bus_i[k*DW-1 -: DW];
    if (int'(sel) < NSRC) return srcs[sel];
    return 32'd0;
  endfunction

  function automatic logic [4:0] destReg();
    logic [4:0] tbl [4];
    tbl[0] = rt_i; tbl[1] = rd_i; tbl[2] = 5'd31; tbl[3] = 5'd0;
    return tbl[reg_dst_i];
  endfunction

  task automatic modelReset();
    mAluM = 0; mWdM = 0; mWregM = 0; mRegwM = 0;
    mHi = 0; mLo = 0; mA = 0; mB = 0; mBusy = 0; mLeft = 0; mOp = 0;
  endtask

  // Architectural result of the finished operation.
  task automatic finishOp();
    longint          sa, sb, p;
    longint unsigned ua, ub, pu;
    sa = longint'($signed(mA)); sb = longint'($signed(mB));
    ua = longint'(mA);          ub = longint'(mB);
    case (mOp)
      2'b00: begin p = sa * sb;  mHi = p[63:32];  mLo = p[31:0];  end
      2'b01: begin pu = ua * ub; mHi = pu[63:32]; mLo = pu[31:0]; end
      2'b10: if (mB != 0) begin p = sa / sb; mLo = p[31:0]; p = sa % sb; mHi = p[31:0]; end
      default: if (mB != 0) begin mLo = mA / mB; mHi = mA % mB; end
    endcase
  endtask

  task automatic checkComb();
    logic [31:0] st;
    st = fwdValue(fwd_rt_i, rd2_i);
    checkOutput("srca", srca_o, fwdValue(fwd_rs_i, rd1_i));
    checkOutput("srcb", srcb_o, alu_src_i ? ext_i : st);
    checkOutput("wreg_e", 32'(wreg_e_o), 32'(destReg()));
  endtask

  task automatic checkRegs();
    checkOutput("alures_m", alures_m_o, mAluM);
    checkOutput("wdata_m", wdata_m_o, mWdM);
    checkOutput("wreg_m", 32'(wreg_m_o), 32'(mWregM));
    checkOutput("regwrite_m", 32'(regwrite_m_o), 32'(mRegwM));
    checkOutput("md_busy", 32'(md_busy_o), 32'(mBusy));
    checkOutput("hi", hi_o, mHi);
    checkOutput("lo", lo_o, mLo);
  endtask

  // Advance the model by one clock edge using the inputs now applied, then
  // let the DUT take the same edge and compare registered outputs.
  task automatic stepCycle();
    logic [31:0] a, b, st;
    a  = fwdValue(fwd_rs_i, rd1_i);
    st = fwdValue(fwd_rt_i, rd2_i);
    b  = alu_src_i ? ext_i : st;
    if (flush_i) begin
      mAluM = 0; mWdM = 0; mWregM = 0; mRegwM = 0;
    end else if (!stall_i) begin
      mAluM = alu_res_i; mWdM = st; mWregM = destReg(); mRegwM = regwrite_i;
    end
    if (mBusy) begin
      mLeft--;
      if (mLeft == 0) begin
        mBusy = 0;
        finishOp();
      end
    end else if (!stall_i) begin
      if (md_start_i) begin
        mBusy = 1;
        mLeft = md_op_i[1] ? DIV_CYC : MUL_CYC;
        mOp = md_op_i; mA = a; mB = b;
      end else begin
        if (md_wr_i[1]) mHi = a;
        if (md_wr_i[0]) mLo = a;
      end
    end
    @(posedge clk);
    #1;
    checkRegs();
  endtask

  task automatic setQuiet();
    stall_i = 0; flush_i = 0; alu_src_i = 0; reg_dst_i = 0; rt_i = 0; rd_i = 0;
    regwrite_i = 0; fwd_rs_i = 0; fwd_rt_i = 0; rd1_i = 0; rd2_i = 0; ext_i = 0;
    fwd_bus_i = '0; alu_res_i = 0; md_start_i = 0; md_op_i = 0; md_wr_i = 0;
  endtask

  // Run cycles until the unit reports idle; returns the busy cycles seen.
  task automatic waitIdle(output int busyCycles);
    busyCycles = 0;
    while (md_busy_o === 1'b1 && busyCycles < 50) begin
      busyCycles++;
      stepCycle();
    end
  endtask

  task automatic applyStimulus();
    logic [31:0] r, a, b;
    stall_i    = ($urandom_range(0, 7) == 0);
    flush_i    = ($urandom_range(0, 9) == 0);
    alu_src_i  = 1'($urandom_range(0, 1));
    reg_dst_i  = 2'($urandom_range(0, 3));
    rt_i       = 5'($urandom_range(0, 31));
    rd_i       = 5'($urandom_range(0, 31));
    regwrite_i = 1'($urandom_range(0, 1));
    fwd_rs_i   = SELW'($urandom_range(0, 7));
    fwd_rt_i   = SELW'($urandom_range(0, 7));
    rd1_i      = $urandom;
    rd2_i      = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
    r          = $urandom;
    ext_i      = ($urandom_range(0, 1) == 1) ? {{24{r[7]}}, r[7:0]} : r;
    fwd_bus_i  = {$urandom, $urandom, $urandom, $urandom};
    alu_res_i  = $urandom;
    md_start_i = ($urandom_range(0, 5) == 0);
    md_op_i    = 2'($urandom_range(0, 3));
    md_wr_i    = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
    a = fwdValue(fwd_rs_i, rd1_i);
    b = alu_src_i ? ext_i : fwdValue(fwd_rt_i, rd2_i);
    if (md_op_i == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) md_op_i = 2'b11;
  endtask

  initial begin
    logic [31:0] expA [6];
    logic [2:0]  selList [6];
    logic [4:0]  expW [4];
    int          busyN;

    expA    = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h0};
    selList = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
    expW    = '{5'd5, 5'd9, 5'd31, 5'd0};

    setQuiet();
    modelReset();
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1;
    checkRegs();
    #3 reset_n = 1;
    @(posedge clk);
    #1;

    // Forward select on rs and on rt
    rd1_i = 32'h11; rd2_i = 32'h11;
    fwd_bus_i = {32'h55, 32'h44, 32'h33, 32'h22};
    alu_src_i = 1; ext_i = 32'hFFFF_8000;
    for (int i = 0; i < 6; i++) begin
      fwd_rs_i = selList[i];
      fwd_rt_i = selList[i];
      #1;
      checkOutput("fwd_rs_srca", srca_o, expA[i]);
      checkOutput("fwd_rt_srcb_imm", srcb_o, 32'hFFFF_8000);
      checkComb();
      stepCycle();
      checkOutput("fwd_rt_wdata", wdata_m_o, expA[i]);
    end

    // Destination register decode
    rt_i = 5'd5; rd_i = 5'd9;
    for (int i = 0; i < 4; i++) begin
      reg_dst_i = 2'(i);
      #1;
      checkOutput("reg_dst", 32'(wreg_e_o), 32'(expW[i]));
    end

    // E/M capture, stall hold, flush over stall
    alu_res_i = 32'hABCD; reg_dst_i = 1; regwrite_i = 1;
    stepCycle();
    for (int i = 0; i < 3; i++) begin
      stall_i = 1; alu_res_i = $urandom; rd_i = 5'($urandom_range(0, 31));
      regwrite_i = 1'($urandom_range(0, 1));
      stepCycle();
      checkOutput("stall_alures", alures_m_o, 32'hABCD);
      checkOutput("stall_wreg", 32'(wreg_m_o), 32'd9);
      checkOutput("stall_regwrite", 32'(regwrite_m_o), 32'd1);
    end
    flush_i = 1;
    stepCycle();
    checkOutput("flush_alures", alures_m_o, 32'd0);
    checkOutput("flush_regwrite", 32'(regwrite_m_o), 32'd0);
    setQuiet();

    // mult / multu with -1 * 2
    for (int op = 0; op < 2; op++) begin
      rd1_i = 32'hFFFF_FFFF; alu_src_i = 1; ext_i = 32'd2;
      md_start_i = 1; md_op_i = 2'(op);
      stepCycle();
      md_start_i = 0;
      waitIdle(busyN);
      checkOutput("mul_busy_cycles", 32'(busyN), 32'(MUL_CYC));
      checkOutput("mul_hi", hi_o, (op == 0) ? 32'hFFFF_FFFF : 32'h1);
      checkOutput("mul_lo", lo_o, 32'hFFFF_FFFE);
    end

    // div -7 / 2
    rd1_i = 32'hFFFF_FFF9; ext_i = 32'd2; md_start_i = 1; md_op_i = 2'b10;
    stepCycle();
    md_start_i = 0;
    waitIdle(busyN);
    checkOutput("div_busy_cycles", 32'(busyN), 32'(DIV_CYC));
    checkOutput("div_lo", lo_o, 32'hFFFF_FFFD);
    checkOutput("div_hi", hi_o, 32'hFFFF_FFFF);

    // divide by zero leaves HI/LO alone
    rd1_i = 32'd77; ext_i = 32'd0; md_start_i = 1; md_op_i = 2'b10;
    stepCycle();
    md_start_i = 0;
    waitIdle(busyN);
    checkOutput("div0_lo", lo_o, 32'hFFFF_FFFD);
    checkOutput("div0_hi", hi_o, 32'hFFFF_FFFF);

    // second start while busy is ignored
    rd1_i = 32'd100; ext_i = 32'd7; md_start_i = 1; md_op_i = 2'b11;
    stepCycle();
    rd1_i = 32'd3; ext_i = 32'd5; md_op_i = 2'b00;
    stepCycle();
    md_start_i = 0;
    waitIdle(busyN);
    checkOutput("restart_lo", lo_o, 32'd14);
    checkOutput("restart_hi", hi_o, 32'd2);

    // reset two cycles into a divide
    rd1_i = 32'd1000; ext_i = 32'd3; md_start_i = 1; md_op_i = 2'b11;
    stepCycle();
    md_start_i = 0;
    stepCycle();
    stepCycle();
    reset_n = 0;
    #1;
    modelReset();
    checkOutput("rst_busy", 32'(md_busy_o), 32'd0);
    checkOutput("rst_hi", hi_o, 32'd0);
    checkOutput("rst_lo", lo_o, 32'd0);
    @(posedge clk);
    #2 reset_n = 1;

    // mthi in idle, then ignored while busy
    rd1_i = 32'h1234; alu_src_i = 0; md_wr_i = 2'b10;
    stepCycle();
    checkOutput("mthi", hi_o, 32'h1234);
    md_wr_i = 0; rd2_i = 32'd3; md_start_i = 1; md_op_i = 2'b01;
    stepCycle();
    md_start_i = 0; rd1_i = 32'h9999; md_wr_i = 2'b10;
    stepCycle();
    checkOutput("mthi_busy", hi_o, 32'h1234);
    md_wr_i = 0;
    waitIdle(busyN);

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      applyStimulus();
      #1;
      checkComb();
      stepCycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
